// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window convolution engine:
// controller states and signed saturation limits for the result path.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int SHIFT_W = 5;

    function automatic logic signed [63:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with post-scaling: the result reflects the
// accumulator including this cycle's product, so the caller can register it
// on the final tap of a window.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DW = 16,
    parameter int K  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic signed [DW-1:0]  a_i,
    input  logic signed [DW-1:0]  b_i,
    input  logic [SHIFT_W-1:0]    shift_i,
    input  logic                  relu_en_i,
    output logic signed [DW-1:0]  result_o
);

    localparam int AW = 2 * DW + $clog2(K * K);

    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [2*DW-1:0] prod_s;
    logic signed [AW-1:0]   sum_s;
    logic signed [AW-1:0]   shifted_s;
    logic signed [63:0]     clamp_s;

    // Product, running sum, then shift / ReLU / saturate on the running sum.
    always_comb begin
        prod_s    = a_i * b_i;
        sum_s     = acc_q + AW'(prod_s);
        shifted_s = sum_s >>> shift_i;
        clamp_s   = 64'(shifted_s);
        if (relu_en_i && (clamp_s < 64'sd0)) begin
            clamp_s = 64'sd0;
        end else begin
            clamp_s = clamp_s;
        end
        if (clamp_s > sat_max(DW)) begin
            clamp_s = sat_max(DW);
        end else if (clamp_s < sat_min(DW)) begin
            clamp_s = sat_min(DW);
        end else begin
            clamp_s = clamp_s;
        end
        result_o = DW'(clamp_s);
        if (clear_i) begin
            acc_d = {AW{1'b0}};
        end else if (enable_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= {AW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_window_engine.sv
// Frame-buffered KxK convolution: loads a full ifmap, then walks output
// windows in raster order, one MAC per cycle, handing each result out.
module conv_window_engine
    import conv_pkg::*;
#(
    parameter int IF_W   = 4,
    parameter int IF_H   = 4,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int DW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K*K*DW-1:0]     weight,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  relu_en,
    input  logic signed [DW-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic signed [DW-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int NPIX = IF_W * IF_H;
    localparam int OH   = (IF_H - K) / STRIDE + 1;
    localparam int OW   = (IF_W - K) / STRIDE + 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    if (K > IF_W || K > IF_H) begin : g_bad_k
        $error("conv_window_engine: K must not exceed IF_W or IF_H");
    end

    state_e                 state_q, state_d;
    logic [31:0]            pix_q, pix_d, kr_q, kr_d, kc_q, kc_d, wr_q, wr_d, wc_q, wc_d;
    logic [K*K*DW-1:0]      weight_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic                   relu_q;
    logic signed [DW-1:0]   dout_q;
    logic                   din_ready_q, dout_valid_q, busy_q, done_q;
    logic signed [DW-1:0]   fb_q [NPIX];
    logic [31:0]            addr_s, kidx_s;
    logic signed [DW-1:0]   pix_s, wgt_s, mac_res_s;
    logic                   mac_clear_s, mac_en_s, last_tap_s, last_win_s;

    // Operand fetch, next-state and counter stepping.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        mac_clear_s = 1'b0;
        mac_en_s    = 1'b0;
        addr_s      = (wr_q * STRIDE + kr_q) * IF_W + wc_q * STRIDE + kc_q;
        kidx_s      = kr_q * K + kc_q;
        pix_s       = fb_q[PW'(addr_s)];
        wgt_s       = $signed(weight_q[kidx_s*DW +: DW]);
        last_tap_s  = (kr_q == K - 1) && (kc_q == K - 1);
        last_win_s  = (wr_q == OH - 1) && (wc_q == OW - 1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    pix_d   = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (din_valid && din_ready_q) begin
                    if (pix_q == NPIX - 1) begin
                        state_d     = MAC;
                        pix_d       = 32'd0;
                        {kr_d, kc_d, wr_d, wc_d} = {4{32'd0}};
                        mac_clear_s = 1'b1;
                    end else begin
                        pix_d = pix_q + 32'd1;
                    end
                end else begin
                    pix_d = pix_q;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (last_tap_s) begin
                    state_d = OUT;
                    kr_d    = 32'd0;
                    kc_d    = 32'd0;
                end else if (kc_q == K - 1) begin
                    kc_d = 32'd0;
                    kr_d = kr_q + 32'd1;
                end else begin
                    kc_d = kc_q + 32'd1;
                end
            end
            OUT: begin
                if (dout_ready && dout_valid_q) begin
                    if (last_win_s) begin
                        state_d = DONE;
                    end else begin
                        state_d     = MAC;
                        mac_clear_s = 1'b1;
                        if (wc_q == OW - 1) begin
                            wc_d = 32'd0;
                            wr_d = wr_q + 32'd1;
                        end else begin
                            wc_d = wc_q + 32'd1;
                        end
                    end
                end else begin
                    state_d = OUT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, configuration capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            {pix_q, kr_q, kc_q, wr_q, wc_q} <= {5{32'd0}};
            weight_q     <= {(K*K*DW){1'b0}};
            shift_q      <= {SHIFT_W{1'b0}};
            relu_q       <= 1'b0;
            dout_q       <= {DW{1'b0}};
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            {pix_q, kr_q, kc_q, wr_q, wc_q} <= {pix_d, kr_d, kc_d, wr_d, wc_d};
            din_ready_q  <= (state_d == LOAD);
            dout_valid_q <= (state_d == OUT);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            if (state_q == IDLE && start) begin
                weight_q <= weight;
                shift_q  <= shift;
                relu_q   <= relu_en;
            end
            if (state_q == MAC && last_tap_s) begin
                dout_q <= mac_res_s;
            end
        end
    end

    // Frame buffer holds data only; it is never reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && din_valid && din_ready_q) begin
            fb_q[PW'(pix_q)] <= din;
        end
    end

    conv_mac_unit #(.DW(DW), .K(K)) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (mac_clear_s),
        .enable_i  (mac_en_s),
        .a_i       (pix_s),
        .b_i       (wgt_s),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .result_o  (mac_res_s)
    );

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_window_engine.sv
// Randomized and directed bench for conv_window_engine, checked against a
// plain-arithmetic convolution model (default 4x4 instance plus a 5x5 stride-2 one).
module tb_conv_window_engine;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, b_start, relu_en, din_valid, dout_ready;
    logic [9*DW-1:0]      weight;
    logic [4:0]           shift;
    logic signed [DW-1:0] din, dout, b_dout;
    logic                 din_ready, dout_valid, busy, done;
    logic                 b_din_ready, b_dout_valid, b_busy, b_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   pix [25];
    int   w   [9];
    int   exp_q [$];

    conv_window_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .weight(weight), .shift(shift),
        .relu_en(relu_en), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    conv_window_engine #(.IF_W(5), .IF_H(5), .K(3), .STRIDE(2), .DW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .weight(weight), .shift(shift),
        .relu_en(relu_en), .din(din), .din_valid(din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(dout_ready),
        .busy(b_busy), .done(b_done)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    // Reference: direct convolution over the stored ifmap.
    task automatic build_exp(input int iw, input int ih, input int st, input int sh, input int rl);
        longint acc;
        exp_q.delete();
        for (int wy = 0; wy <= (ih - 3) / st; wy++) begin
            for (int wx = 0; wx <= (iw - 3) / st; wx++) begin
                acc = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        acc += longint'(pix[(wy*st+ky)*iw + wx*st+kx]) * longint'(w[ky*3+kx]);
                acc = acc >>> sh;
                if (rl != 0 && acc < 0) acc = 0;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                exp_q.push_back(int'(acc));
            end
        end
    endtask

    task automatic start_frame(input int sel, input int sh, input int rl);
        @(negedge clk);
        for (int i = 0; i < 9; i++) weight[i*DW +: DW] = w[i][DW-1:0];
        shift   = sh[4:0];
        relu_en = rl[0];
        if (sel != 0) b_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        b_start = 1'b0;
        check_val("busy_after_start", (sel != 0) ? b_busy : busy, 1);
    endtask

    task automatic load_frame(input int sel, input int npix, input int gaps);
        int   idx = 0;
        int   cyc = 0;
        logic rdy;
        while (idx < npix && cyc < 1000) begin
            rdy       = (sel != 0) ? b_din_ready : din_ready;
            din_valid = (gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            din       = pix[idx][DW-1:0];
            @(posedge clk);
            if (din_valid && rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        din_valid = 1'b0;
        check_val("pixels_loaded", idx, npix);
    endtask

    task automatic collect(input int sel, input int hold5);
        int   k = 0;
        int   cyc = 0;
        int   held = 0;
        int   ndone = 0;
        logic v;
        logic signed [DW-1:0] d;
        while (k < exp_q.size() && cyc < 2000) begin
            v = (sel != 0) ? b_dout_valid : dout_valid;
            d = (sel != 0) ? b_dout : dout;
            if (v || held > 0) begin
                check_val($sformatf("dout_valid_%0d", k), v, 1);
                check_val($sformatf("dout_%0d", k), d, exp_q[k]);
                if (hold5 != 0 && held < 5) begin
                    dout_ready = 1'b0;
                    held++;
                end else begin
                    dout_ready = (hold5 != 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (dout_ready) begin
                        k++;
                        held = 0;
                    end
                end
            end else begin
                dout_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        dout_ready = 1'b0;
        check_val("outputs_taken", k, exp_q.size());
        for (int i = 0; i < 20; i++) begin
            if ((sel != 0) ? b_done : done) ndone++;
            check_val("no_extra_output", (sel != 0) ? b_dout_valid : dout_valid, 0);
            @(negedge clk);
        end
        check_val("done_pulses", ndone, 1);
        check_val("idle_after_done", (sel != 0) ? b_busy : busy, 0);
    endtask

    task automatic run_frame(input int sel, input int iw, input int ih, input int st,
                             input int sh, input int rl, input int gaps, input int hold5);
        build_exp(iw, ih, st, sh, rl);
        start_frame(sel, sh, rl);
        load_frame(sel, iw * ih, gaps);
        collect(sel, hold5);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy", busy, 0);
        check_val("rst_din_ready", din_ready, 0);
        check_val("rst_dout_valid", dout_valid, 0);
        check_val("rst_dout", dout, 0);
        check_val("rst_done", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; b_start = 1'b0; relu_en = 1'b0;
        din_valid = 1'b0; dout_ready = 1'b0; weight = '0; shift = 5'd0; din = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) pix[i] = i + 1;
        for (int i = 0; i < 9; i++) w[i] = 1;
        run_frame(0, 4, 4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) w[i] = -1;
        run_frame(0, 4, 4, 1, 0, 0, 1, 0);
        run_frame(0, 4, 4, 1, 0, 1, 1, 0);

        for (int i = 0; i < 16; i++) pix[i] = 32767;
        for (int i = 0; i < 9; i++) w[i] = 32767;
        run_frame(0, 4, 4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) pix[i] = -32768;
        run_frame(0, 4, 4, 1, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) pix[i] = i + 1;
        for (int i = 0; i < 9; i++) w[i] = 1;
        run_frame(0, 4, 4, 1, 0, 0, 0, 1);

        start_frame(0, 0, 0);
        load_frame(0, 16, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs();
        run_frame(0, 4, 4, 1, 0, 0, 0, 0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 16; i++) pix[i] = rnd16();
            for (int i = 0; i < 9; i++) w[i] = rnd16();
            run_frame(0, 4, 4, 1, int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 1, f % 2);
        end

        for (int i = 0; i < 25; i++) pix[i] = i + 1;
        for (int i = 0; i < 9; i++) w[i] = 1;
        run_frame(1, 5, 5, 2, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
